// File: rtl/float_mantissa_divider_if.sv
// float_mantissa_divider_if: operand/result handshake bundle for the significand divider.
interface float_mantissa_divider_if #(parameter int N = 8);
    logic         valid_in;
    logic         ready_in;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         valid_out;
    logic         ready_out;
    logic [N-1:0] quotient;
    logic [1:0]   sticky;
    logic         exp_dec;
    logic         div_zero;
    modport master (
        output valid_in, dividend, divisor, ready_out,
        input  ready_in, valid_out, quotient, sticky, exp_dec, div_zero
    );
    modport slave (
        input  valid_in, dividend, divisor, ready_out,
        output ready_in, valid_out, quotient, sticky, exp_dec, div_zero
    );
endinterface

// File: rtl/float_mantissa_divider.sv
// float_mantissa_divider: restoring significand divider, one quotient bit per clock.
// Optional FLOAT_MANTISSA_DIVIDER_EARLY_EXIT_EN stops as soon as the partial remainder is zero.
module float_mantissa_divider #(parameter int N = 8) (
    input logic clock,
    input logic reset,
    float_mantissa_divider_if.slave io
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int CW = $clog2(N + 2);
    state_t state, state_nx;
    logic [N:0] r, diff;
    logic [N-1:0] b;
    logic [N+1:0] q, q_nx;
    logic [CW-1:0] cnt;
    logic ge, zero_rem, fin, accept;
    logic [N-1:0] quotient;
    logic [1:0] sticky;
    logic exp_dec, div_zero;
    always_comb begin
        ge = r >= {1'b0, b};
        diff = ge ? r - {1'b0, b} : r;
        q_nx = q | ((N + 2)'(ge) << cnt);
        zero_rem = diff == '0;
`ifdef FLOAT_MANTISSA_DIVIDER_EARLY_EXIT_EN
        fin = cnt == '0 || zero_rem;
`else
        fin = cnt == '0;
`endif
        accept = state == IDLE && io.valid_in;
        state_nx = state == IDLE ? (io.valid_in ? ((io.divisor == '0 || io.dividend == '0) ? DONE : CALC) : IDLE)
                 : state == CALC ? (fin ? DONE : CALC)
                 : (io.ready_out ? IDLE : DONE);
    end
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r <= '0;
            b <= '0;
            q <= '0;
            cnt <= '0;
            quotient <= '0;
            sticky <= '0;
            exp_dec <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            r <= {1'b0, io.dividend};
            b <= io.divisor;
            q <= '0;
            cnt <= CW'(N + 1);
            quotient <= '0;
            sticky <= '0;
            exp_dec <= 1'b0;
            div_zero <= io.divisor == '0;
        end else if (state == CALC) begin
            r <= diff << 1;
            q <= q_nx;
            cnt <= cnt - CW'(1);
            // q_nx below the current bit is still zero, so early exit normalizes identically
            if (fin) begin
                quotient <= q_nx[N+1] ? q_nx[N+1:2] : q_nx[N:1];
                sticky <= q_nx[N+1] ? {q_nx[1], q_nx[0] | !zero_rem} : {q_nx[0], !zero_rem};
                exp_dec <= !q_nx[N+1];
            end
        end
    end
    assign io.ready_in  = state == IDLE;
    assign io.valid_out = state == DONE;
    assign io.quotient  = quotient;
    assign io.sticky    = sticky;
    assign io.exp_dec   = exp_dec;
    assign io.div_zero  = div_zero;
endmodule

// File: tb/tb_float_mantissa_divider.sv
// tb_float_mantissa_divider: directed table, corner sequences and random operands vs. an arithmetic model.
module tb_float_mantissa_divider;
    localparam int N = 8;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int lat;
    always #5 clock = ~clock;

    float_mantissa_divider_if #(.N(N)) io();
    float_mantissa_divider #(.N(N)) dut (.clock(clock), .reset(reset), .io(io));

    typedef struct {
        logic [7:0] a, b, q;
        logic [1:0] s;
        logic e, z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // quotient bits are floor(A * 2^(N+1) / B); normalize to N bits plus round/sticky
    function automatic void model(input logic [7:0] a, b, output logic [7:0] q, output logic [1:0] s,
                                  output logic e, output logic z);
        int num, qf, rem;
        q = 0; s = 0; e = 0; z = (b == 0);
        if (b == 0 || a == 0) return;
        num = int'(a) << (N + 1);
        qf = num / int'(b);
        rem = num % int'(b);
        if (qf >= (1 << (N + 1))) begin
            q = 8'(qf >> 2);
            s = {qf[1], qf[0] | (rem != 0)};
        end else begin
            q = 8'(qf >> 1);
            s = {qf[0], rem != 0};
            e = 1;
        end
    endfunction

    function automatic int exp_lat(input logic [7:0] a, b);
        if (a == 0 || b == 0) return 0;
`ifdef FLOAT_MANTISSA_DIVIDER_EARLY_EXIT_EN
        for (int k = 1; k <= N + 2; k++)
            if (((int'(a) << (k - 1)) % int'(b)) == 0) return k;
`endif
        return N + 2;
    endfunction

    task automatic start(input logic [7:0] a, b);
        chk("ready_before_accept", io.ready_in, 1);
        io.valid_in = 1; io.dividend = a; io.divisor = b;
        @(posedge clock); #1;
        io.valid_in = 0;
        lat = 0;
    endtask

    task automatic wait_done;
        while (!io.valid_out && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] a, b, q, input logic [1:0] s,
                             input logic e, z);
        chk({tag, "_valid"}, io.valid_out, 1);
        chk({tag, "_lat"}, lat, exp_lat(a, b));
        chk({tag, "_q"}, io.quotient, q);
        chk({tag, "_s"}, io.sticky, s);
        chk({tag, "_e"}, io.exp_dec, e);
        chk({tag, "_z"}, io.div_zero, z);
    endtask

    task automatic release_out(input int stall);
        logic [7:0] q0;
        logic [1:0] s0;
        q0 = io.quotient; s0 = io.sticky;
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            chk("stall_valid", io.valid_out, 1);
            chk("stall_ready_in", io.ready_in, 0);
            chk("stall_q", io.quotient, q0);
            chk("stall_s", io.sticky, s0);
        end
        io.ready_out = 1;
        @(posedge clock); #1;
        io.ready_out = 0;
        chk("post_hs_valid", io.valid_out, 0);
        chk("post_hs_ready", io.ready_in, 1);
    endtask

    initial begin
        vec_t tbl[7];
        logic [7:0] a, b, mq;
        logic [1:0] ms;
        logic me, mz;
        tbl[0] = '{8'h80, 8'h80, 8'h80, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{8'h80, 8'hC0, 8'hAA, 2'b11, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'h80, 8'hFF, 2'b00, 1'b0, 1'b0};
        tbl[3] = '{8'hC0, 8'h80, 8'hC0, 2'b00, 1'b0, 1'b0};
        tbl[4] = '{8'h55, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 8'h90, 8'h00, 2'b00, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 8'hFF, 8'h80, 2'b11, 1'b1, 1'b0};
        io.valid_in = 0; io.dividend = 0; io.divisor = 0; io.ready_out = 0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        chk("rst_ready", io.ready_in, 1);
        chk("rst_valid", io.valid_out, 0);
        chk("rst_outs", {io.quotient, io.sticky, io.exp_dec, io.div_zero}, 0);

        foreach (tbl[i]) begin
            start(tbl[i].a, tbl[i].b);
            wait_done();
            check_out($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].s, tbl[i].e, tbl[i].z);
            release_out(0);
        end

        // backpressure plus operands offered mid-calculation
        start(8'h80, 8'hC0);
        repeat (3) begin
            @(posedge clock); #1;
            lat++;
        end
        io.valid_in = 1; io.dividend = 8'hFF; io.divisor = 8'h80;
        chk("calc_ready_in", io.ready_in, 0);
        wait_done();
        io.valid_in = 0;
        check_out("ignored_in", 8'h80, 8'hC0, 8'hAA, 2'b11, 1'b1, 1'b0);
        release_out(5);

        // reset in the 4th CALC cycle discards the in-flight result
        start(8'hFF, 8'h80);
        repeat (3) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1;
        reset = 0;
        chk("midrst_valid", io.valid_out, 0);
        chk("midrst_ready", io.ready_in, 1);
        chk("midrst_outs", {io.quotient, io.sticky, io.exp_dec, io.div_zero}, 0);
        start(8'h80, 8'hC0);
        wait_done();
        check_out("after_rst", 8'h80, 8'hC0, 8'hAA, 2'b11, 1'b1, 1'b0);
        release_out(0);

        for (int i = 0; i < 60; i++) begin
            a = 8'h80 | 8'($urandom);
            b = 8'h80 | 8'($urandom);
            if ($urandom_range(0, 9) == 0) a = 0;
            if ($urandom_range(0, 9) == 0) b = 0;
            if ($urandom_range(0, 7) == 0) b = a;
            model(a, b, mq, ms, me, mz);
            start(a, b);
            wait_done();
            check_out($sformatf("rnd%0d", i), a, b, mq, ms, me, mz);
            release_out($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
